// File: rtl/arc4_pkg.sv
// Shared types and constants for the ARC4 top-level sequencer.
package arc4_pkg;

    localparam int unsigned DEF_TIMEOUT_CYCLES = 4096;
    localparam int unsigned ADDR_W             = 8;
    localparam int unsigned DATA_W             = 8;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT_GO,
        ST_INIT_WAIT,
        ST_KSA_GO,
        ST_KSA_WAIT,
        ST_PRGA_GO,
        ST_PRGA_WAIT,
        ST_DONE,
        ST_ERR
    } sched_state_t;

    typedef enum logic [1:0] {
        PH_NONE = 2'd0,
        PH_INIT = 2'd1,
        PH_KSA  = 2'd2,
        PH_PRGA = 2'd3
    } phase_t;

    // One phase module's request to the single-port S memory.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wrdata;
        logic              wren;
    } s_req_t;

endpackage

// File: rtl/s_mem_mux.sv
// S-memory port arbiter: the selected phase owns the port, everyone else is
// dropped and flagged if it tries to write.
module s_mem_mux
    import arc4_pkg::*;
(
    input  phase_t i_sel,
    input  s_req_t i_init,
    input  s_req_t i_ksa,
    input  s_req_t i_prga,
    output s_req_t o_req,
    output logic   o_conflict
);

    always_comb begin
        o_req      = '0;
        o_conflict = 1'b0;
        case (i_sel)
            PH_INIT: begin
                o_req      = i_init;
                o_conflict = i_ksa.wren | i_prga.wren;
            end
            PH_KSA: begin
                o_req      = i_ksa;
                o_conflict = i_init.wren | i_prga.wren;
            end
            PH_PRGA: begin
                o_req      = i_prga;
                o_conflict = i_init.wren | i_ksa.wren;
            end
            default: begin
                // No owner: any write request is from a non-owner.
                o_conflict = i_init.wren | i_ksa.wren | i_prga.wren;
            end
        endcase
    end

endmodule

// File: rtl/arc4_sched.sv
// ARC4 top-level sequencer: runs init, KSA and PRGA in order via rdy/en
// handshakes, guards each phase with a watchdog and grants the S memory.
module arc4_sched
    import arc4_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              rdy,
    output logic              done,
    output logic              err,
    output logic              conflict,
    output logic [1:0]        phase,
    output logic              init_en,
    output logic              ksa_en,
    output logic              prga_en,
    input  logic              init_rdy,
    input  logic              ksa_rdy,
    input  logic              prga_rdy,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [ADDR_W-1:0] ksa_addr,
    input  logic [ADDR_W-1:0] prga_addr,
    input  logic [DATA_W-1:0] init_wrdata,
    input  logic [DATA_W-1:0] ksa_wrdata,
    input  logic [DATA_W-1:0] prga_wrdata,
    input  logic              init_wren,
    input  logic              ksa_wren,
    input  logic              prga_wren,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wrdata,
    output logic              s_wren
);

    sched_state_t     r_state;
    phase_t           r_phase;
    logic [CNT_W-1:0] r_cnt;
    logic             r_started;
    logic             r_rdy;
    logic             r_done;
    logic             r_err;
    logic             r_conflict;
    logic             r_init_en;
    logic             r_ksa_en;
    logic             r_prga_en;

    logic             w_cur_rdy;
    logic             w_in_wait;
    logic             w_complete;
    logic             w_expired;
    sched_state_t     w_wait_state;
    sched_state_t     w_next_state;
    phase_t           w_next_phase;
    s_req_t           w_req;
    logic             w_conflict;

    // Per-phase view of the active phase: its rdy and where it goes next.
    always_comb begin
        w_cur_rdy    = 1'b0;
        w_wait_state = ST_IDLE;
        w_next_state = ST_IDLE;
        w_next_phase = PH_NONE;
        case (r_phase)
            PH_INIT: begin
                w_cur_rdy    = init_rdy;
                w_wait_state = ST_INIT_WAIT;
                w_next_state = ST_KSA_GO;
                w_next_phase = PH_KSA;
            end
            PH_KSA: begin
                w_cur_rdy    = ksa_rdy;
                w_wait_state = ST_KSA_WAIT;
                w_next_state = ST_PRGA_GO;
                w_next_phase = PH_PRGA;
            end
            PH_PRGA: begin
                w_cur_rdy    = prga_rdy;
                w_wait_state = ST_PRGA_WAIT;
                w_next_state = ST_DONE;
                w_next_phase = PH_NONE;
            end
            default: ;
        endcase
    end

    assign w_in_wait  = (r_state == ST_INIT_WAIT) || (r_state == ST_KSA_WAIT) ||
                        (r_state == ST_PRGA_WAIT);
    assign w_complete = w_in_wait && w_cur_rdy && r_started;
    assign w_expired  = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Sequencer FSM, watchdog and sticky status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_phase    <= PH_NONE;
            r_cnt      <= '0;
            r_started  <= 1'b0;
            r_rdy      <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_conflict <= 1'b0;
            r_init_en  <= 1'b0;
            r_ksa_en   <= 1'b0;
            r_prga_en  <= 1'b0;
        end else begin
            r_init_en  <= 1'b0;
            r_ksa_en   <= 1'b0;
            r_prga_en  <= 1'b0;
            r_conflict <= r_conflict | w_conflict;
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (en) begin
                        r_state    <= ST_INIT_GO;
                        r_phase    <= PH_INIT;
                        r_cnt      <= '0;
                        r_started  <= 1'b0;
                        r_rdy      <= 1'b0;
                        r_done     <= 1'b0;
                        r_err      <= 1'b0;
                        r_conflict <= 1'b0;
                    end
                end
                ST_INIT_GO, ST_KSA_GO, ST_PRGA_GO: begin
                    r_started <= 1'b0;
                    r_cnt     <= r_cnt + CNT_W'(1);
                    if (w_expired) begin
                        r_state <= ST_ERR;
                        r_phase <= PH_NONE;
                        r_err   <= 1'b1;
                        r_rdy   <= 1'b1;
                    end else if (w_cur_rdy) begin
                        r_state   <= w_wait_state;
                        r_init_en <= (r_phase == PH_INIT);
                        r_ksa_en  <= (r_phase == PH_KSA);
                        r_prga_en <= (r_phase == PH_PRGA);
                    end
                end
                ST_INIT_WAIT, ST_KSA_WAIT, ST_PRGA_WAIT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (!w_cur_rdy) begin
                        r_started <= 1'b1;
                    end
                    // Completion beats a same-cycle watchdog expiry.
                    if (w_complete) begin
                        r_state   <= w_next_state;
                        r_phase   <= w_next_phase;
                        r_cnt     <= '0;
                        r_started <= 1'b0;
                        if (w_next_state == ST_DONE) begin
                            r_done <= 1'b1;
                            r_rdy  <= 1'b1;
                        end
                    end else if (w_expired) begin
                        r_state <= ST_ERR;
                        r_phase <= PH_NONE;
                        r_err   <= 1'b1;
                        r_rdy   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_phase <= PH_NONE;
                    r_rdy   <= 1'b1;
                end
            endcase
        end
    end

    s_mem_mux u_mux (
        .i_sel      (r_phase),
        .i_init     ('{addr: init_addr, wrdata: init_wrdata, wren: init_wren}),
        .i_ksa      ('{addr: ksa_addr,  wrdata: ksa_wrdata,  wren: ksa_wren}),
        .i_prga     ('{addr: prga_addr, wrdata: prga_wrdata, wren: prga_wren}),
        .o_req      (w_req),
        .o_conflict (w_conflict)
    );

    assign s_addr   = w_req.addr;
    assign s_wrdata = w_req.wrdata;
    assign s_wren   = w_req.wren & ~rst;

    assign rdy      = r_rdy;
    assign done     = r_done;
    assign err      = r_err;
    assign conflict = r_conflict;
    assign phase    = r_phase;
    assign init_en  = r_init_en;
    assign ksa_en   = r_ksa_en;
    assign prga_en  = r_prga_en;

endmodule

// File: doc/arc4_sched.md
Name: arc4_sched

Overview:
- Top-level sequencer for the ARC4 pipeline.
- On one start request it runs init (S[i]=i), then KSA, then PRGA, each via the rdy/en handshake.
- Grants the single-port S memory to whichever phase is active.
- Sits between the board-level wrapper (which maps KEY and CLOCK_50 to en, rst and clk) and the three phase modules.

Parameters:
- TIMEOUT_CYCLES, 4096: maximum cycles any one phase may stay busy before an error.
- CNT_W, $clog2(TIMEOUT_CYCLES+1): width of the watchdog counter.

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- en  in  1  start request; honoured only while rdy=1
- rdy  out  1  scheduler idle and able to accept en
- done  out  1  all three phases completed; sticky until next accepted en or rst
- err  out  1  watchdog expired; sticky until next accepted en or rst
- conflict  out  1  sticky: a non-owner drove wren=1
- phase  out  2  0=none, 1=init, 2=ksa, 3=prga
- init_en / ksa_en / prga_en  out  1 each  one-cycle start pulses to the phase modules
- init_rdy / ksa_rdy / prga_rdy  in  1 each  phase module idle
- init_addr, ksa_addr, prga_addr  in  8 each  S-memory address requests
- init_wrdata, ksa_wrdata, prga_wrdata  in  8 each  S-memory write data
- init_wren, ksa_wren, prga_wren  in  1 each  S-memory write enables
- s_addr  out  8  to S memory
- s_wrdata  out  8  to S memory
- s_wren  out  1  to S memory

Behaviour:
- Reset values: state IDLE, rdy=1, done=0, err=0, conflict=0, phase=0, all *_en=0, s_addr=0, s_wrdata=0, s_wren=0. s_wren is forced 0 combinationally while rst=1.
- States: IDLE, INIT_GO, INIT_WAIT, KSA_GO, KSA_WAIT, PRGA_GO, PRGA_WAIT, DONE, ERR.
- IDLE/DONE/ERR:
  - rdy=1.
  - en=1 moves to INIT_GO on the next edge and clears done, err and conflict.
  - en while rdy=0 is ignored.
- X_GO:
  - Waits until X_rdy=1, then asserts X_en for exactly one cycle and moves to X_WAIT.
  - The started flag and watchdog counter are cleared.
- X_WAIT:
  - The started flag is set on the first cycle X_rdy=0.
  - Completion is X_rdy=1 with started=1.
  - On completion: init goes to KSA_GO, ksa to PRGA_GO, prga to DONE.
  - Completion and the GO of the next phase are in separate cycles, so one idle cycle sits between phases.
- Watchdog:
  - Counter increments every cycle in X_GO and X_WAIT.
  - At count == TIMEOUT_CYCLES-1 without completion, the next state is ERR and err=1.
  - Completion on the same cycle as expiry wins, so no error is raised.
- Memory mux:
  - Combinational from the registered state, zero latency.
  - init owns the port in INIT_GO/INIT_WAIT; ksa and prga likewise for their states.
  - In all other states: s_addr=0, s_wrdata=0, s_wren=0.
- Non-owner requests are dropped. If a non-owner drives wren=1, conflict is set one cycle later and stays set.
- phase output reflects the owner; it is 0 in IDLE/DONE/ERR.
- done=1 in DONE only; err=1 in ERR only.
- Reset mid-operation: next edge returns to IDLE and all *_en go low. Phase modules are reset by the same rst.

Decomposition:
- arc4_pkg holds:
  - sched_state_t enum
  - phase_t enum (PH_NONE, PH_INIT, PH_KSA, PH_PRGA)
  - the default TIMEOUT_CYCLES constant
- One sub-module, s_mem_mux:
  - Inputs: phase_t select plus the three request bundles.
  - Outputs: the s_* signals and a conflict pulse.
  - Contents: purely combinational mux.
- FSM, watchdog and sticky flags stay in arc4_sched.

Test Plan:
- Nominal run: mock phases busy for 256, 768 and 512 cycles. Pulse en → exactly one init_en, then ksa_en, then prga_en, each one cycle and in order. done=1 and rdy=1 after prga_rdy rises; err=0.
- Mux ownership: during INIT_WAIT drive init_addr=8'h2A, init_wren=1 and ksa_wren=1 → s_addr=8'h2A, s_wren=1, conflict=1 one cycle later. In IDLE any wren gives s_wren=0.
- Timeout: TIMEOUT_CYCLES=64 with ksa_rdy held low forever → ERR at the 64th cycle after entering KSA_GO, err=1, s_wren=0, prga_en never pulses.
- Busy en: pulse en during KSA_WAIT → ignored, no extra init_en. A second en after DONE → done clears and the full sequence restarts.
- Late start: ksa_rdy=0 for 10 cycles at KSA_GO entry → ksa_en is held off until ksa_rdy=1, then pulses once.
- Mid-run reset: assert rst for 1 cycle during PRGA_WAIT → s_wren=0 during that cycle, IDLE after the edge, all *_en=0, done=0, rdy=1.
